// File: rtl/sd_adc.sv
// sd_adc: first-order sigma-delta ADC front end.
// Synchronises the external comparator bit and returns it as the integrator
// feedback. The feedback bitstream is decimated with a boxcar window of
// 2^(RES+1) clocks. One full window is discarded after every enable so the
// analog loop can settle, and windows then run back to back.
module sd_adc #(
  parameter int RES = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         comp_in,
  output logic         fb_out,
  output logic [RES:0] adc_out,
  output logic         adc_valid,
  output logic         busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SETTLE  = 2'b01,
    ST_CONVERT = 2'b10
  } state_t;

  localparam logic [RES:0]   CNT_ONE  = {{RES{1'b0}}, 1'b1};
  localparam logic [RES:0]   CNT_ZERO = {(RES+1){1'b0}};
  localparam logic [RES+1:0] ACC_ZERO = {(RES+2){1'b0}};

  // A full window of ones (count W) does not fit in RES+1 bits, so it is
  // clamped to all ones instead of wrapping to zero.
  function automatic logic [RES:0] sat_count(input logic [RES+1:0] cnt);
    logic [RES:0] res;
    if (cnt[RES+1]) begin
      res = {(RES+1){1'b1}};
    end else begin
      res = cnt[RES:0];
    end
    return res;
  endfunction

  logic         comp_meta_r;
  logic         comp_sync_r;
  logic         fb_r;
  state_t       state_r;
  state_t       state_nxt_s;
  logic [RES:0]   win_cnt_r;
  logic [RES:0]   win_cnt_nxt_s;
  logic [RES+1:0] acc_r;
  logic [RES+1:0] acc_nxt_s;
  logic [RES+1:0] sum_s;
  logic [RES:0]   adc_out_r;
  logic [RES:0]   adc_out_nxt_s;
  logic           adc_valid_r;
  logic           adc_valid_nxt_s;
  logic           busy_r;
  logic           win_end_s;

  assign fb_out    = fb_r;
  assign adc_out   = adc_out_r;
  assign adc_valid = adc_valid_r;
  assign busy      = busy_r;

  // The comparator synchroniser and the feedback flop run in every state so the loop stays balanced.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      comp_meta_r <= 1'b0;
      comp_sync_r <= 1'b0;
      fb_r        <= 1'b0;
    end else begin
      comp_meta_r <= comp_in;
      comp_sync_r <= comp_meta_r;
      fb_r        <= comp_sync_r;
    end
  end

  assign win_end_s = &win_cnt_r;
  assign sum_s     = acc_r + {{(RES+1){1'b0}}, fb_r};

  // Next-state logic: sequences window counting, accumulation and sample strobes.
  always_comb begin
    state_nxt_s     = state_r;
    win_cnt_nxt_s   = win_cnt_r;
    acc_nxt_s       = acc_r;
    adc_out_nxt_s   = adc_out_r;
    adc_valid_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        win_cnt_nxt_s = CNT_ZERO;
        acc_nxt_s     = ACC_ZERO;
        if (en) begin
          state_nxt_s = ST_SETTLE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        // The accumulator is held at zero; this window only lets the loop settle.
        acc_nxt_s = ACC_ZERO;
        if (!en) begin
          state_nxt_s   = ST_IDLE;
          win_cnt_nxt_s = CNT_ZERO;
        end else if (win_end_s) begin
          state_nxt_s   = ST_CONVERT;
          win_cnt_nxt_s = CNT_ZERO;
        end else begin
          win_cnt_nxt_s = win_cnt_r + CNT_ONE;
        end
      end
      ST_CONVERT: begin
        if (win_end_s) begin
          // A window end always emits its sample, even if en drops on this clock.
          adc_out_nxt_s   = sat_count(sum_s);
          adc_valid_nxt_s = 1'b1;
          acc_nxt_s       = ACC_ZERO;
          win_cnt_nxt_s   = CNT_ZERO;
          if (en) begin
            state_nxt_s = ST_CONVERT;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else if (!en) begin
          // Drop the partial window without a strobe.
          state_nxt_s   = ST_IDLE;
          win_cnt_nxt_s = CNT_ZERO;
          acc_nxt_s     = ACC_ZERO;
        end else begin
          acc_nxt_s     = sum_s;
          win_cnt_nxt_s = win_cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        win_cnt_nxt_s = CNT_ZERO;
        acc_nxt_s     = ACC_ZERO;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      win_cnt_r   <= CNT_ZERO;
      acc_r       <= ACC_ZERO;
      adc_out_r   <= CNT_ZERO;
      adc_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      win_cnt_r   <= win_cnt_nxt_s;
      acc_r       <= acc_nxt_s;
      adc_out_r   <= adc_out_nxt_s;
      adc_valid_r <= adc_valid_nxt_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_sd_adc.sv
// tb_sd_adc: directed test of sd_adc with RES=7 (256-clock windows).
// Inputs change 1 ns after each rising edge, and outputs are sampled at the same point.
module tb_sd_adc;

  logic       clk;
  logic       reset;
  logic       en;
  logic       comp_in;
  logic       fb_out;
  logic [7:0] adc_out;
  logic       adc_valid;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int comp_mode = 0;   // 0: const 0, 1: const 1, 2: toggle, 3: dac loop
  logic [7:0] dac_acc = 8'h00;
  int n;
  int vc;

  sd_adc #(.RES(7)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .comp_in   (comp_in),
    .fb_out    (fb_out),
    .adc_out   (adc_out),
    .adc_valid (adc_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input logic [31:0] obs,
                             input logic [31:0] lo, input logic [31:0] hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h..0x%0h", tag, obs, lo, hi);
    end
  endtask

  // Advance one clock and drive the next comparator bit.
  task automatic tick();
    logic [8:0] s;
    @(posedge clk);
    #1;
    case (comp_mode)
      0: comp_in = 1'b0;
      1: comp_in = 1'b1;
      2: comp_in = ~comp_in;
      default: begin
        // First-order 1-bit dac fed with 0x40: carry-out density is 64/256.
        s = {1'b0, dac_acc} + 9'h040;
        dac_acc = s[7:0];
        comp_in = s[8];
      end
    endcase
  endtask

  // Tick until adc_valid is seen or the budget runs out; n = ticks taken.
  task automatic wait_valid(input int max, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (adc_valid !== 1'b1 && cnt < max);
  endtask

  initial begin
    reset = 1'b0;
    en = 1'b0;
    comp_in = 1'b0;
    repeat (3) tick();
    check("rst_fb_out", fb_out, 0);
    check("rst_adc_out", adc_out, 8'h00);
    check("rst_adc_valid", adc_valid, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    repeat (2) tick();
    check("idle_busy", busy, 0);

    // comp_in = 0: accepting edge is the next edge, strobe 512 edges later.
    en = 1'b1;
    tick();
    check("en_busy", busy, 1);
    wait_valid(600, n);
    check("zero_first_latency", n, 512);
    check("zero_adc_out", adc_out, 8'h00);
    tick();
    check("zero_valid_one_cycle", adc_valid, 0);
    wait_valid(300, n);
    check("zero_period", n, 255);
    check("zero_adc_out2", adc_out, 8'h00);

    // comp_in = 1: 256 ones saturate to 0xFF.
    en = 1'b0;
    tick();
    check("drop_busy", busy, 0);
    check("drop_hold", adc_out, 8'h00);
    comp_mode = 1;
    repeat (5) tick();
    en = 1'b1;
    wait_valid(600, n);
    check("ones_latency", n, 513);
    check("ones_adc_out", adc_out, 8'hFF);
    wait_valid(300, n);
    check("ones_period", n, 256);
    check("ones_adc_out2", adc_out, 8'hFF);

    // Toggling comp_in: 128 ones per window.
    en = 1'b0;
    tick();
    comp_mode = 2;
    repeat (5) tick();
    en = 1'b1;
    wait_valid(600, n);
    check("tog_latency", n, 513);
    check("tog_adc_out", adc_out, 8'h80);
    wait_valid(300, n);
    check("tog_period", n, 256);
    check("tog_adc_out2", adc_out, 8'h80);

    // en dropped at window count 100: no strobe, output held, full restart.
    repeat (100) tick();
    en = 1'b0;
    tick();
    check("mid_drop_busy", busy, 0);
    check("mid_drop_valid", adc_valid, 0);
    check("mid_drop_hold", adc_out, 8'h80);
    vc = 0;
    repeat (300) begin
      tick();
      if (adc_valid === 1'b1) vc++;
    end
    check("idle_no_strobe", vc, 0);
    en = 1'b1;
    wait_valid(600, n);
    check("reen_latency", n, 513);
    check("reen_adc_out", adc_out, 8'h80);

    // en dropped on the window-end clock: the strobe still fires, then IDLE.
    repeat (255) tick();
    en = 1'b0;
    tick();
    check("end_drop_valid", adc_valid, 1);
    check("end_drop_busy", busy, 0);
    check("end_drop_adc_out", adc_out, 8'h80);
    tick();
    check("end_drop_valid_off", adc_valid, 0);

    // Asynchronous reset between edges in the middle of CONVERT.
    comp_mode = 1;
    en = 1'b1;
    wait_valid(600, n);
    check("pre_rst_adc_out", adc_out, 8'hFF);
    repeat (50) tick();
    #2;
    reset = 1'b0;
    #1;
    check("arst_adc_out", adc_out, 8'h00);
    check("arst_busy", busy, 0);
    check("arst_fb_out", fb_out, 0);
    check("arst_valid", adc_valid, 0);
    en = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_valid", adc_valid, 0);

    // Closed loop with a behavioural 1-bit dac at 0x40.
    comp_mode = 3;
    en = 1'b1;
    wait_valid(600, n);
    check("dac_latency", n, 513);
    check_range("dac_adc_out", adc_out, 8'h3F, 8'h41);
    wait_valid(300, n);
    check("dac_period", n, 256);
    check_range("dac_adc_out2", adc_out, 8'h3F, 8'h41);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
